data_mem_responder: RTL and testbench

- Responder side of the single-cycle CPU's data-memory port (MemWrite, Mem_WrAddr, Mem_WrData, ReadData).
- Provides word RAM plus a small memory-mapped I/O page: GPIO output register, free-running cycle counter, byte TX FIFO with a valid/ready drain port, and status/overflow register.
- Reads are combinational so the CPU completes loads in one cycle; all writes and state updates occur on the rising clk edge.

---
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an MMIO page
// holding GPIO, a free-running cycle counter, a byte TX FIFO and its status.
module data_mem_responder #(
  parameter int          DEPTH      = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GPIO_W     = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Mem_WrAddr,
  input  logic [31:0]       Mem_WrData,
  output logic [31:0]       ReadData,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_overflow
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  localparam logic [1:0] REG_GPIO   = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [31:0]       ram_q [DEPTH];
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              in_ram, in_mmio;
  logic [1:0]        reg_sel;
  logic [AW-1:0]     word_idx;
  logic              wr_ram, wr_gpio, wr_cycle, wr_status;
  logic              push, push_ok, pop, full, empty;
  logic [31:0]       status;
  logic              unused_addr_lsbs;

  // Byte offset within the word is irrelevant: all accesses are word-aligned.
  assign unused_addr_lsbs = ^Mem_WrAddr[1:0];

  assign in_ram   = Mem_WrAddr < RAM_BYTES;
  assign in_mmio  = Mem_WrAddr[31:4] == MMIO_BASE[31:4];
  assign reg_sel  = Mem_WrAddr[3:2];
  assign word_idx = Mem_WrAddr[AW+1:2];

  assign wr_ram    = MemWrite && in_ram;
  assign wr_gpio   = MemWrite && in_mmio && (reg_sel == REG_GPIO);
  assign wr_cycle  = MemWrite && in_mmio && (reg_sel == REG_CYCLE);
  assign push      = MemWrite && in_mmio && (reg_sel == REG_TXDATA);
  assign wr_status = MemWrite && in_mmio && (reg_sel == REG_STATUS);

  assign full    = count_q == CW'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign pop     = !empty && tx_ready;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  assign status = {16'h0, 8'(count_q), 5'h0, ovf_q, empty, full};

  always_comb begin
    ReadData = 32'h0;
    if (in_ram) begin
      ReadData = ram_q[word_idx];
    end else if (in_mmio) begin
      case (reg_sel)
        REG_GPIO:   ReadData = 32'(gpio_q);
        REG_CYCLE:  ReadData = cycle_q;
        REG_TXDATA: ReadData = 32'h0;
        default:    ReadData = status;
      endcase
    end
  end

  always_comb begin
    gpio_d   = wr_gpio ? Mem_WrData[GPIO_W-1:0] : gpio_q;
    cycle_d  = wr_cycle ? Mem_WrData : cycle_q + 32'd1;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push && !push_ok) ovf_d = 1'b1;
    // Clearing write wins over a same-cycle overflow.
    if (wr_status && Mem_WrData[2]) ovf_d = 1'b0;
  end

  // Storage arrays are not reset; the FIFO head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[word_idx] <= Mem_WrData;
    if (push_ok) fifo_q[wr_ptr_q] <= Mem_WrData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q   <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gpio_out    = gpio_q;
  assign tx_valid    = !empty;
  assign tx_data     = empty ? 8'h0 : fifo_q[rd_ptr_q];
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed test-plan sequences with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          FD    = 8;
  localparam int          GW    = 8;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] GMASK = 32'h0000_00FF;
  localparam logic [31:0] RAMB  = 32'(DEPTH * 4);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite = 1'b0;
  logic [31:0]   Mem_WrAddr = '0;
  logic [31:0]   Mem_WrData = '0;
  logic [31:0]   ReadData;
  logic [GW-1:0] gpio_out;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_overflow;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .DEPTH(DEPTH), .FIFO_DEPTH(FD), .GPIO_W(GW), .MMIO_BASE(BASE)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData), .ReadData(ReadData), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] ram_m [DEPTH];
  bit          ram_k [DEPTH];
  logic [31:0] gpio_m = '0;
  logic [31:0] cyc_m  = '0;
  logic [7:0]  q_m [$];
  bit          ovf_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  task automatic exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int sz = q_m.size();
    known = 1'b1;
    v = 32'h0;
    if (a < RAMB) begin
      known = ram_k[a / 4];
      v = ram_m[a / 4];
    end else if (is_mmio(a)) begin
      case (a[3:2])
        2'd0: v = gpio_m;
        2'd1: v = cyc_m;
        2'd2: v = 32'h0;
        default: v = (sz << 8) | (32'(ovf_m) << 2) | (32'(sz == 0) << 1) | 32'(sz == FD);
      endcase
    end
  endtask

  task automatic compare_all();
    logic [31:0] v;
    bit known;
    exp_read(Mem_WrAddr, v, known);
    if (known) check("ReadData", ReadData, v);
    check("gpio_out", 32'(gpio_out), gpio_m);
    check("tx_valid", 32'(tx_valid), 32'(q_m.size() > 0));
    check("tx_data", 32'(tx_data), (q_m.size() > 0) ? 32'(q_m[0]) : 32'h0);
    check("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
  endtask

  task automatic model_edge();
    int sz = q_m.size();
    bit pop, push;
    bit mm = is_mmio(Mem_WrAddr);
    logic [1:0] off = Mem_WrAddr[3:2];
    if (reset) begin
      gpio_m = '0;
      cyc_m  = '0;
      q_m.delete();
      ovf_m  = 1'b0;
      return;
    end
    pop  = (sz > 0) && tx_ready;
    push = MemWrite && mm && (off == 2'd2);
    if (MemWrite && Mem_WrAddr < RAMB) begin
      ram_m[Mem_WrAddr / 4] = Mem_WrData;
      ram_k[Mem_WrAddr / 4] = 1'b1;
    end
    if (MemWrite && mm && off == 2'd0) gpio_m = Mem_WrData & GMASK;
    cyc_m = (MemWrite && mm && off == 2'd1) ? Mem_WrData : cyc_m + 32'd1;
    if (pop) void'(q_m.pop_front());
    if (push) begin
      if (sz == FD && !pop) ovf_m = 1'b1;
      else q_m.push_back(Mem_WrData[7:0]);
    end
    if (MemWrite && mm && off == 2'd3 && Mem_WrData[2]) ovf_m = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, advance model at the edge.
  task automatic cyc();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic setin(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite   = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    setin(1'b1, a, d);
    cyc();
  endtask

  task automatic rd(input logic [31:0] a);
    setin(1'b0, a, 32'h0);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset = 1'b1;
    setin(1'b0, 32'h0, 32'h0);
    @(posedge clk); model_edge(); #1;
    cyc();
    reset = 1'b0;
    rd(BASE + 32'hC);
    check("rst_status", ReadData, 32'h0000_0002);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_valid", 32'(tx_valid), 32'h0);
    cyc();

    // RAM round-trip and out-of-range access
    wr(32'h0, 32'h1111_1111);
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd(32'h10); check("ram_10", ReadData, 32'hDEAD_BEEF);
    rd(32'h13); check("ram_13", ReadData, 32'hDEAD_BEEF);
    cyc();
    rd(32'h14); check("ram_14", ReadData, 32'h1234_5678);
    rd(RAMB);   check("ram_oor_rd", ReadData, 32'h0);
    cyc();
    wr(RAMB, 32'hFFFF_FFFF);
    rd(32'h0);  check("ram_oor_wr", ReadData, 32'h1111_1111);
    cyc();

    // GPIO and CYCLE
    wr(BASE, 32'h0000_00A5);
    check("gpio_a5", 32'(gpio_out), 32'h0000_00A5);
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    rd(BASE + 32'h4); check("cyc_load", ReadData, 32'hFFFF_FFFE); cyc();
    rd(BASE + 32'h4); check("cyc_ff", ReadData, 32'hFFFF_FFFF); cyc();
    rd(BASE + 32'h4); check("cyc_wrap", ReadData, 32'h0); cyc();
    rd(BASE + 32'h4); check("cyc_one", ReadData, 32'h1); cyc();

    // FIFO basic
    tx_ready = 1'b0;
    wr(BASE + 32'h8, 32'h41);
    wr(BASE + 32'h8, 32'h42);
    wr(BASE + 32'h8, 32'h43);
    rd(BASE + 32'hC); check("fifo3_status", ReadData, 32'h0000_0300);
    tx_ready = 1'b1;
    #1; check("drain_41", 32'(tx_data), 32'h41); check("drain_v", 32'(tx_valid), 32'h1);
    cyc(); check("drain_42", 32'(tx_data), 32'h42);
    cyc(); check("drain_43", 32'(tx_data), 32'h43);
    cyc(); check("drain_empty", 32'(tx_valid), 32'h0);
    rd(BASE + 32'hC); check("empty_status", ReadData, 32'h0000_0002);
    cyc();

    // Overflow and clear
    tx_ready = 1'b0;
    for (int i = 0; i <= FD; i++) wr(BASE + 32'h8, 32'h50 + 32'(i));
    rd(BASE + 32'hC); check("ovf_status", ReadData, 32'h0000_0805);
    check("ovf_flag", 32'(tx_overflow), 32'h1);
    wr(BASE + 32'hC, 32'h4);
    check("ovf_clear", 32'(tx_overflow), 32'h0);
    tx_ready = 1'b1;
    setin(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < FD; i++) begin
      #1; check("ovf_drain", 32'(tx_data), 32'h50 + 32'(i));
      cyc();
    end
    check("ovf_last_absent", 32'(tx_valid), 32'h0);

    // Full with simultaneous push and pop
    tx_ready = 1'b0;
    for (int i = 0; i < FD; i++) wr(BASE + 32'h8, 32'h60 + 32'(i));
    tx_ready = 1'b1;
    wr(BASE + 32'h8, 32'h99);
    tx_ready = 1'b0;
    rd(BASE + 32'hC); check("full_pp_status", ReadData, 32'h0000_0801);
    tx_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      #1; check("full_pp_drain", 32'(tx_data), (i < FD - 1) ? 32'h61 + 32'(i) : 32'h99);
      cyc();
    end
    check("full_pp_empty", 32'(tx_valid), 32'h0);

    // Reset mid-operation
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(BASE + 32'h8, 32'h70 + 32'(i));
    wr(BASE, 32'h3C);
    wr(BASE + 32'h4, 32'd100);
    rd(BASE + 32'h4); check("pre_rst_cyc", ReadData, 32'd100);
    check("pre_rst_gpio", 32'(gpio_out), 32'h3C);
    cyc();
    reset = 1'b1;
    setin(1'b1, BASE, 32'hFF);
    cyc();
    reset = 1'b0;
    rd(BASE + 32'h4);
    check("rst_gpio0", 32'(gpio_out), 32'h0);
    check("rst_txv0", 32'(tx_valid), 32'h0);
    check("rst_txd0", 32'(tx_data), 32'h0);
    check("rst_cyc0", ReadData, 32'h0);
    cyc();
    rd(BASE + 32'h4); check("rst_cyc1", ReadData, 32'h1);
    rd(32'h10); check("rst_ram10", ReadData, 32'hDEAD_BEEF);
    cyc();
    rd(32'h14); check("rst_ram14", ReadData, 32'h1234_5678);
    cyc();

    // Randomized traffic; ready probability alternates to exercise full/empty
    for (int n = 0; n < 3000; n++) begin
      int k, rp;
      logic [31:0] a;
      logic we;
      rp = ((n / 300) % 2 == 0) ? 60 : 8;
      k = $urandom_range(0, 9);
      if (k <= 3) a = $urandom_range(0, DEPTH * 4 - 1);
      else if (k <= 7) a = BASE + {28'h0, ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else if (k == 8) a = $urandom;
      else a = RAMB + 32'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      if (reset && a < RAMB) we = 1'b0;
      tx_ready = ($urandom_range(0, 99) < rp);
      setin(we, a, $urandom);
      cyc();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
